// File: rtl/dram_arb_pkg.sv
// dram_arb_pkg: shared types and defaults for the data-RAM arbiter.
// Holds arbiter state encoding, port-owner encoding and default widths.
package dram_arb_pkg;

    localparam int AW_DEF = 10;
    localparam int DW_DEF = 32;

    typedef enum logic [1:0] {
        ARB  = 2'd0,
        LOCK = 2'd1,
        COOL = 2'd2
    } arb_state_e;

    typedef enum logic {
        OWN_CPU = 1'b0,
        OWN_DMA = 1'b1
    } owner_e;

endpackage

// File: rtl/dram_arb_rdret.sv
// dram_arb_rdret: 1-deep owner/valid pipeline for RAM read returns.
// Steers the registered RAM read data to whichever port issued the read.
module dram_arb_rdret
    import dram_arb_pkg::*;
#(
    parameter int DW = DW_DEF
) (
    input  logic          i_clk,
    input  logic          i_rst,
    input  logic          i_en,
    input  logic          i_c_rd,
    input  logic          i_d_rd,
    input  logic [DW-1:0] i_ram_rdata,
    output logic          o_c_rvalid,
    output logic [DW-1:0] o_c_rdata,
    output logic          o_d_rvalid,
    output logic [DW-1:0] o_d_rdata
);

    logic   valid_q;
    owner_e own_q;
    logic   live;

    // Record who issued a read this cycle; hold while the clock enable is low.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            valid_q <= 1'b0;
            own_q   <= OWN_DMA;
        end else if (i_en) begin
            valid_q <= i_c_rd | i_d_rd;
            own_q   <= i_c_rd ? OWN_CPU : OWN_DMA;
        end
    end

    // A held return is presented only on enabled cycles, so it pulses once.
    always_comb begin
        live       = valid_q & i_en & ~i_rst;
        o_c_rvalid = live & (own_q == OWN_CPU);
        o_d_rvalid = live & (own_q == OWN_DMA);
        o_c_rdata  = o_c_rvalid ? i_ram_rdata : '0;
        o_d_rdata  = o_d_rvalid ? i_ram_rdata : '0;
    end

endmodule

// File: rtl/dram_arbiter.sv
// dram_arbiter: shares the single-port data RAM between CPU and DMA ports.
// Define DRAM_ARB_RR_EN for round-robin conflicts; default is fixed CPU priority.
module dram_arbiter
    import dram_arb_pkg::*;
#(
    parameter int AW        = AW_DEF,
    parameter int DW        = DW_DEF,
    parameter int MAX_BURST = 8
) (
    input  logic          i_clk,
    input  logic          i_rst,
    input  logic          i_clk_en,
    input  logic          i_c_req,
    input  logic          i_c_we,
    input  logic [AW-1:0] i_c_addr,
    input  logic [DW-1:0] i_c_wdata,
    output logic          o_c_gnt,
    output logic          o_c_rvalid,
    output logic [DW-1:0] o_c_rdata,
    input  logic          i_d_req,
    input  logic          i_d_lock,
    input  logic          i_d_we,
    input  logic [AW-1:0] i_d_addr,
    input  logic [DW-1:0] i_d_wdata,
    output logic          o_d_gnt,
    output logic          o_d_rvalid,
    output logic [DW-1:0] o_d_rdata,
    output logic          o_ram_cs,
    output logic          o_ram_we,
    output logic [AW-1:0] o_ram_addr,
    output logic [DW-1:0] o_ram_wdata,
    input  logic [DW-1:0] i_ram_rdata
);

    localparam logic [7:0] MAXB = 8'(MAX_BURST);

    arb_state_e state_q, state_d;
    logic [7:0] cnt_q, cnt_d;
    logic       arb_cpu, arb_dma;

`ifdef DRAM_ARB_RR_EN
    owner_e last_q, last_d;

    // Open arbitration: on conflict the port not granted last time wins.
    always_comb begin
        arb_dma = i_d_req & (~i_c_req | (last_q == OWN_CPU));
        arb_cpu = i_c_req & ~arb_dma;
    end

    // Every issued grant, locked or not, updates the last winner.
    always_comb begin
        last_d = last_q;
        if (o_c_gnt) last_d = OWN_CPU;
        if (o_d_gnt) last_d = OWN_DMA;
    end

    // Last-winner register; reset favours the CPU on the first conflict.
    always_ff @(posedge i_clk) begin
        if (i_rst) last_q <= OWN_DMA;
        else if (i_clk_en) last_q <= last_d;
    end
`else
    // Open arbitration: the CPU wins every conflict.
    always_comb begin
        arb_cpu = i_c_req;
        arb_dma = i_d_req & ~i_c_req;
    end
`endif

    // Grant and next-state logic; a broken lock falls back to open arbitration.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        o_c_gnt = 1'b0;
        o_d_gnt = 1'b0;
        if (i_clk_en && !i_rst) begin
            unique case (state_q)
                ARB: begin
                    o_c_gnt = arb_cpu;
                    o_d_gnt = arb_dma;
                    if (arb_dma && i_d_lock) begin
                        cnt_d   = 8'd1;
                        state_d = (MAXB == 8'd1) ? COOL : LOCK;
                    end
                end
                LOCK: begin
                    if (i_d_req && i_d_lock) begin
                        o_d_gnt = 1'b1;
                        cnt_d   = cnt_q + 8'd1;
                        if (cnt_q + 8'd1 == MAXB) state_d = COOL;
                    end else begin
                        o_c_gnt = arb_cpu;
                        o_d_gnt = arb_dma;
                        cnt_d   = 8'd0;
                        state_d = ARB;
                    end
                end
                COOL: begin
                    o_c_gnt = i_c_req;
                    cnt_d   = 8'd0;
                    state_d = ARB;
                end
                default: begin
                    cnt_d   = 8'd0;
                    state_d = ARB;
                end
            endcase
        end
    end

    // State and burst counter; both freeze while the clock enable is low.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q <= ARB;
            cnt_q   <= 8'd0;
        end else if (i_clk_en) begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // The winner drives the RAM port in the same cycle; idle port reads as zero.
    always_comb begin
        o_ram_cs    = o_c_gnt | o_d_gnt;
        o_ram_we    = 1'b0;
        o_ram_addr  = '0;
        o_ram_wdata = '0;
        if (o_c_gnt) begin
            o_ram_we    = i_c_we;
            o_ram_addr  = i_c_addr;
            o_ram_wdata = i_c_wdata;
        end else if (o_d_gnt) begin
            o_ram_we    = i_d_we;
            o_ram_addr  = i_d_addr;
            o_ram_wdata = i_d_wdata;
        end
    end

    dram_arb_rdret #(
        .DW(DW)
    ) u_rdret (
        .i_clk       (i_clk),
        .i_rst       (i_rst),
        .i_en        (i_clk_en),
        .i_c_rd      (o_c_gnt & ~i_c_we),
        .i_d_rd      (o_d_gnt & ~i_d_we),
        .i_ram_rdata (i_ram_rdata),
        .o_c_rvalid  (o_c_rvalid),
        .o_c_rdata   (o_c_rdata),
        .o_d_rvalid  (o_d_rvalid),
        .o_d_rdata   (o_d_rdata)
    );

endmodule

// File: tb/tb_dram_arbiter.sv
// tb_dram_arbiter: directed and random stimulus against a transaction-level model.
// Model tracks remaining burst grants, cool-off and pending read per port.
module tb_dram_arbiter;

    localparam int AW   = 10;
    localparam int DW   = 32;
    localparam int MAXB = 4;

    logic          clk = 1'b0;
    logic          rst, en;
    logic          c_req, c_we, d_req, d_lock, d_we;
    logic [AW-1:0] c_addr, d_addr;
    logic [DW-1:0] c_wdata, d_wdata;
    logic          c_gnt, c_rvalid, d_gnt, d_rvalid;
    logic [DW-1:0] c_rdata, d_rdata;
    logic          ram_cs, ram_we;
    logic [AW-1:0] ram_addr;
    logic [DW-1:0] ram_wdata, ram_q;

    logic [DW-1:0] mem  [1024];
    logic [DW-1:0] emem [1024];

    int errors = 0;
    int checks = 0;

    int            lock_left;
    bit            cool, last_dma;
    int            pend;
    logic [DW-1:0] pdata;
    bit            ecg, edg;

    always #5 clk = ~clk;

    dram_arbiter #(.AW(AW), .DW(DW), .MAX_BURST(MAXB)) dut (
        .i_clk       (clk),
        .i_rst       (rst),
        .i_clk_en    (en),
        .i_c_req     (c_req),
        .i_c_we      (c_we),
        .i_c_addr    (c_addr),
        .i_c_wdata   (c_wdata),
        .o_c_gnt     (c_gnt),
        .o_c_rvalid  (c_rvalid),
        .o_c_rdata   (c_rdata),
        .i_d_req     (d_req),
        .i_d_lock    (d_lock),
        .i_d_we      (d_we),
        .i_d_addr    (d_addr),
        .i_d_wdata   (d_wdata),
        .o_d_gnt     (d_gnt),
        .o_d_rvalid  (d_rvalid),
        .o_d_rdata   (d_rdata),
        .o_ram_cs    (ram_cs),
        .o_ram_we    (ram_we),
        .o_ram_addr  (ram_addr),
        .o_ram_wdata (ram_wdata),
        .i_ram_rdata (ram_q)
    );

    // Synchronous single-port RAM with one-cycle read latency.
    always @(posedge clk) begin
        if (ram_cs) begin
            if (ram_we) mem[ram_addr] <= ram_wdata;
            else ram_q <= mem[ram_addr];
        end
    end

    task automatic check(string tag, logic [DW-1:0] got, logic [DW-1:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic drive(bit cr, bit cw, int ca, bit dr, bit dl, bit dw, int da);
        c_req   = cr;
        c_we    = cw;
        c_addr  = AW'(ca);
        c_wdata = $urandom;
        d_req   = dr;
        d_lock  = dl;
        d_we    = dw;
        d_addr  = AW'(da);
        d_wdata = $urandom;
    endtask

    task automatic step();
        logic          e_we;
        logic [AW-1:0] e_addr;
        logic [DW-1:0] e_wd;
        bit            live;
        #1;
        ecg = 0;
        edg = 0;
        if (!rst && en) begin
            if (cool) ecg = c_req;
            else if (lock_left > 0 && d_req && d_lock) edg = 1;
            else if (c_req && d_req) begin
`ifdef DRAM_ARB_RR_EN
                edg = !last_dma;
`else
                edg = 0;
`endif
                ecg = !edg;
            end else begin
                ecg = c_req;
                edg = d_req;
            end
        end
        e_we   = ecg ? c_we : (edg ? d_we : 1'b0);
        e_addr = ecg ? c_addr : (edg ? d_addr : '0);
        e_wd   = ecg ? c_wdata : (edg ? d_wdata : '0);
        live   = !rst && en;
        check("c_gnt", DW'(c_gnt), DW'(ecg));
        check("d_gnt", DW'(d_gnt), DW'(edg));
        check("ram_cs", DW'(ram_cs), DW'(ecg | edg));
        check("ram_we", DW'(ram_we), DW'(e_we));
        check("ram_addr", DW'(ram_addr), DW'(e_addr));
        check("ram_wdata", ram_wdata, e_wd);
        check("c_rvalid", DW'(c_rvalid), DW'(live && pend == 1));
        check("c_rdata", c_rdata, (live && pend == 1) ? pdata : '0);
        check("d_rvalid", DW'(d_rvalid), DW'(live && pend == 2));
        check("d_rdata", d_rdata, (live && pend == 2) ? pdata : '0);
        @(posedge clk);
        if (rst) begin
            lock_left = 0;
            cool      = 0;
            last_dma  = 1;
            pend      = 0;
        end else if (en) begin
            pend = 0;
            if (ecg && !c_we) begin pend = 1; pdata = emem[c_addr]; end
            if (edg && !d_we) begin pend = 2; pdata = emem[d_addr]; end
            if (ecg && c_we) emem[c_addr] = c_wdata;
            if (edg && d_we) emem[d_addr] = d_wdata;
            if (ecg || edg) last_dma = edg;
            if (cool) begin
                cool      = 0;
                lock_left = 0;
            end else if (edg && d_lock) begin
                if (lock_left > 0) lock_left--;
                else lock_left = MAXB - 1;
                if (lock_left == 0) cool = 1;
            end else begin
                lock_left = 0;
            end
        end
        @(negedge clk);
    endtask

    initial begin
        for (int i = 0; i < 1024; i++) begin
            mem[i]  = i * 32'h9E3779B1;
            emem[i] = i * 32'h9E3779B1;
        end
        mem[16]  = 32'hDEADBEEF;
        emem[16] = 32'hDEADBEEF;
        ram_q     = '0;
        lock_left = 0;
        cool      = 0;
        last_dma  = 1;
        pend      = 0;
        pdata     = '0;
        rst = 1;
        en  = 1;
        drive(0, 0, 0, 0, 0, 0, 0);
        @(negedge clk);
        step();
        drive(1, 0, 16, 1, 0, 0, 5);
        step();
        rst = 0;
        // CPU read of preloaded word
        drive(1, 0, 16, 0, 0, 0, 0);
        step();
        drive(0, 0, 0, 0, 0, 0, 0);
        step();
        check("dir_c_rdata", c_rdata, 32'h0);
        // both ports contend
        for (int i = 0; i < 4; i++) begin
            drive(1, 0, i, 1, 0, 0, 100 + i);
            step();
        end
        drive(0, 0, 0, 1, 0, 0, 200);
        step();
        // locked DMA burst with CPU pressing
        for (int i = 0; i < 7; i++) begin
            drive(1, 0, 300 + i, 1, 1, 0, 400 + i);
            step();
        end
        // DMA write then CPU read back
        drive(0, 0, 0, 1, 0, 1, 0);
        d_wdata = 32'h55AA;
        d_addr  = 10'h3FF;
        step();
        drive(1, 0, 10'h3FF, 0, 0, 0, 0);
        step();
        drive(0, 0, 0, 0, 0, 0, 0);
        step();
        // clock-enable drop in the middle of a burst
        for (int i = 0; i < 10; i++) begin
            en = !(i >= 2 && i < 5);
            drive(0, 0, 0, 1, 1, 0, 500 + i);
            step();
        end
        en = 1;
        // reset right after a granted read
        drive(1, 0, 16, 0, 0, 0, 0);
        step();
        rst = 1;
        drive(0, 0, 0, 0, 0, 0, 0);
        step();
        rst = 0;
        drive(1, 0, 7, 1, 0, 0, 8);
        step();
        drive(0, 0, 0, 0, 0, 0, 0);
        step();
        // random traffic
        for (int i = 0; i < 500; i++) begin
            rst = ($urandom_range(0, 49) == 0);
            en  = ($urandom_range(0, 9) != 0);
            drive($urandom_range(0, 1), $urandom_range(0, 1), $urandom_range(0, 31),
                  $urandom_range(0, 1), $urandom_range(0, 3) != 0,
                  $urandom_range(0, 1), $urandom_range(0, 31));
            step();
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
